// File: rtl/pl_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, handshakes with instruction memory, inserts
// load-use stalls, applies EX redirects and halts. Optional stall counter: FETCH_STALL_CNT_EN.
module pl_fetch_ctrl #(
  parameter int PROG_CTR_WID = 10,
  parameter int RESET_VEC    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [PROG_CTR_WID-1:0] imem_addr,
  input  logic                    imem_valid,
  input  logic [15:0]             imem_rdata,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target_EX,
  input  logic                    load_true_IFID,
  input  logic [2:0]              res_addr_IFID,
  input  logic                    halt_req,
  input  logic                    resume,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    stall_IF,
  output logic                    bubble_ID,
  output logic                    flush_IF,
  output logic                    flush_ID,
  output logic                    halted,
  output logic [15:0]             stall_cnt
);

  localparam logic [PROG_CTR_WID-1:0] RESET_PC = PROG_CTR_WID'(RESET_VEC);

  typedef enum logic [2:0] {IDLE, FETCH, STALL, REDIRECT, HALT} state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [PROG_CTR_WID-1:0] pc_next;
  logic                    hazard;
  logic                    branch_live;

  // Only the two register-source fields of the fetched word matter for hazard detection.
  logic unused_rdata;
  assign unused_rdata = ^{imem_rdata[15:7], imem_rdata[3]};

  assign imem_addr = prog_ctr;
  assign hazard = load_true_IFID &&
                  ((res_addr_IFID == imem_rdata[2:0]) || (res_addr_IFID == imem_rdata[6:4]));
  assign branch_live = branch_taken_EX &&
                       ((state_reg == FETCH) || (state_reg == STALL) || (state_reg == REDIRECT));

  always_comb begin
    state_next = state_reg;
    pc_next    = prog_ctr;
    if (branch_live) begin
      pc_next    = branch_target_EX;
      state_next = REDIRECT;
    end else begin
      case (state_reg)
        IDLE:     state_next = FETCH;
        FETCH: begin
          if (imem_valid) begin
            if (hazard) begin
              state_next = STALL;
            end else begin
              pc_next    = prog_ctr + 1'b1;
              state_next = halt_req ? HALT : FETCH;
            end
          end
        end
        STALL:    state_next = halt_req ? HALT : FETCH;
        REDIRECT: state_next = FETCH;
        HALT:     if (resume) state_next = FETCH;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      prog_ctr  <= RESET_PC;
      imem_req  <= 1'b0;
      stall_IF  <= 1'b0;
      bubble_ID <= 1'b0;
      flush_IF  <= 1'b0;
      flush_ID  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_reg <= state_next;
      prog_ctr  <= pc_next;
      imem_req  <= (state_next == FETCH);
      stall_IF  <= (state_next == STALL);
      bubble_ID <= (state_next == STALL);
      flush_IF  <= (state_next == REDIRECT);
      flush_ID  <= (state_next == REDIRECT);
      halted    <= (state_next == HALT);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] cnt_reg;
  logic        count_en;

  assign count_en = (state_reg == STALL) || (state_reg == REDIRECT) || (imem_req && !imem_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= 16'h0000;
    end else if (count_en && (cnt_reg != 16'hFFFF)) begin
      cnt_reg <= cnt_reg + 16'h0001;
    end
  end

  assign stall_cnt = cnt_reg;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
